// File: rtl/qerv_pkg.sv
// Shared types and encodings for the serial data-bus interface.
package qerv_pkg;

  // Bus interface controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REQ     = 2'd2,
    ST_RETURN  = 2'd3
  } state_t;

  // Access size encodings; 2'b11 behaves as a word access
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // A request is rejected when the byte offset does not fit the access size
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lsb[0];
      default: bad = (lsb != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/qerv_dbus_lane.sv
// Combinational byte-lane steering: select mask, store replication, load align.
module qerv_dbus_lane
  import qerv_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lsb,
  input  logic [31:0] st_data,
  input  logic [31:0] rdt,
  output logic [3:0]  sel,
  output logic [31:0] dat,
  output logic [31:0] ld_data
);

  // Lane mask and replicated store data depend only on the access size and offset
  always_comb begin
    sel = 4'b1111;
    dat = st_data;
    case (size)
      SZ_BYTE: begin
        sel = 4'b0001 << lsb;
        dat = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        sel = 4'b0011 << lsb;
        dat = {2{st_data[15:0]}};
      end
      default: begin
        sel = 4'b1111;
        dat = st_data;
      end
    endcase
  end

  // Right-align the addressed bytes of the read word
  assign ld_data = rdt >> {lsb, 3'b000};

endmodule

// File: rtl/qerv_dbus_if.sv
// Serial-to-Wishbone data bus interface: collects store data serially,
// performs one Wishbone transfer, and streams load data back serially.
module qerv_dbus_if
  import qerv_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_we,
  input  logic [1:0]                i_size,
  input  logic                      i_signed,
  input  logic [31:0]               i_adr,
  input  logic [1:0]                i_lsb,
  input  logic                      i_en,
  input  logic [BITS_PER_CYCLE-1:0] i_rs2,
  output logic [BITS_PER_CYCLE-1:0] o_rd,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_misalign,
  output logic [31:0]               o_wb_adr,
  output logic [31:0]               o_wb_dat,
  output logic [3:0]                o_wb_sel,
  output logic                      o_wb_we,
  output logic                      o_wb_cyc,
  input  logic [31:0]               i_wb_rdt,
  input  logic                      i_wb_ack
);

  localparam int BEATS = 32 / BITS_PER_CYCLE;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0]   data_reg, data_next;
  logic          we_reg, we_next;
  logic [1:0]    size_reg, size_next;
  logic          signed_reg, signed_next;
  logic [1:0]    lsb_reg, lsb_next;
  logic [31:0]   adr_next, dat_next;
  logic [3:0]    sel_next;
  logic          wbwe_next, cyc_next, done_next, mis_next;

  logic [31:0]   shift_data;
  logic [1:0]    lane_size, lane_lsb;
  logic [3:0]    lane_sel;
  logic [31:0]   lane_dat, lane_ld;
  logic          sign_bit;
  logic [5:0]    ret_width;
  logic          unused_adr;

  assign unused_adr = ^i_adr[1:0];

  // New store data enters at the MSB end so the word is LSB-aligned after BEATS shifts
  assign shift_data = {i_rs2, data_reg[31:BITS_PER_CYCLE]};

  // In IDLE the request fields are not latched yet, so steer with the live inputs
  assign lane_size = (state_reg == ST_IDLE) ? i_size : size_reg;
  assign lane_lsb  = (state_reg == ST_IDLE) ? i_lsb  : lsb_reg;

  qerv_dbus_lane u_lane (
    .size    (lane_size),
    .lsb     (lane_lsb),
    .st_data (shift_data),
    .rdt     (i_wb_rdt),
    .sel     (lane_sel),
    .dat     (lane_dat),
    .ld_data (lane_ld)
  );

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      data_reg   <= '0;
      we_reg     <= 1'b0;
      size_reg   <= SZ_BYTE;
      signed_reg <= 1'b0;
      lsb_reg    <= 2'b00;
      o_wb_adr   <= '0;
      o_wb_dat   <= '0;
      o_wb_sel   <= '0;
      o_wb_we    <= 1'b0;
      o_wb_cyc   <= 1'b0;
      o_done     <= 1'b0;
      o_misalign <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      data_reg   <= data_next;
      we_reg     <= we_next;
      size_reg   <= size_next;
      signed_reg <= signed_next;
      lsb_reg    <= lsb_next;
      o_wb_adr   <= adr_next;
      o_wb_dat   <= dat_next;
      o_wb_sel   <= sel_next;
      o_wb_we    <= wbwe_next;
      o_wb_cyc   <= cyc_next;
      o_done     <= done_next;
      o_misalign <= mis_next;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    data_next   = data_reg;
    we_next     = we_reg;
    size_next   = size_reg;
    signed_next = signed_reg;
    lsb_next    = lsb_reg;
    adr_next    = o_wb_adr;
    dat_next    = o_wb_dat;
    sel_next    = o_wb_sel;
    wbwe_next   = o_wb_we;
    cyc_next    = o_wb_cyc;
    done_next   = 1'b0;
    mis_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          if (is_misaligned(i_size, i_lsb)) begin
            mis_next = 1'b1;
          end else begin
            we_next     = i_we;
            size_next   = i_size;
            signed_next = i_signed;
            lsb_next    = i_lsb;
            cnt_next    = '0;
            if (i_we) begin
              state_next = ST_COLLECT;
            end else begin
              state_next = ST_REQ;
              cyc_next   = 1'b1;
              wbwe_next  = 1'b0;
              sel_next   = lane_sel;
              adr_next   = {i_adr[31:2], 2'b00};
              dat_next   = '0;
            end
          end
        end
      end
      ST_COLLECT: begin
        if (i_en) begin
          data_next = shift_data;
          cnt_next  = cnt_reg + CW'(1);
          if (cnt_reg == LAST_BEAT) begin
            state_next = ST_REQ;
            cyc_next   = 1'b1;
            wbwe_next  = 1'b1;
            sel_next   = lane_sel;
            adr_next   = {i_adr[31:2], 2'b00};
            dat_next   = lane_dat;
          end
        end
      end
      ST_REQ: begin
        if (o_wb_cyc && i_wb_ack) begin
          cyc_next  = 1'b0;
          wbwe_next = 1'b0;
          sel_next  = 4'b0000;
          if (we_reg) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            data_next  = lane_ld;
            cnt_next   = '0;
            state_next = ST_RETURN;
          end
        end
      end
      ST_RETURN: begin
        if (i_en) begin
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == LAST_BEAT) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Significant width of the load and the bit used for extension
  always_comb begin
    ret_width = 6'd32;
    sign_bit  = data_reg[31];
    case (size_reg)
      SZ_BYTE: begin
        ret_width = 6'd8;
        sign_bit  = data_reg[7];
      end
      SZ_HALF: begin
        ret_width = 6'd16;
        sign_bit  = data_reg[15];
      end
      default: begin
        ret_width = 6'd32;
        sign_bit  = data_reg[31];
      end
    endcase
  end

  // Each serial output lane picks its data bit or the extension bit
  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_rd
      logic [5:0] pos;
      logic       bit_val;
      assign pos     = 6'(cnt_reg) * 6'(BITS_PER_CYCLE) + 6'(gi);
      assign bit_val = (pos < ret_width) ? data_reg[pos[4:0]] : (signed_reg & sign_bit);
      assign o_rd[gi] = (state_reg == ST_RETURN) && i_en && bit_val;
    end
  endgenerate

  assign o_busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_qerv_dbus_if.sv
// Directed testbench for qerv_dbus_if with a 1-bit and a 4-bit serial instance.
module tb_qerv_dbus_if;
  import qerv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, sgn;
  logic [1:0]  size, lsb_in;
  logic [31:0] adr, wb_rdt;
  logic        wb_ack;

  // 1-bit instance
  logic        start1, en1;
  logic [0:0]  rs2_1, rd1;
  logic        busy1, done1, mis1, wbwe1, cyc1;
  logic [31:0] wbadr1, wbdat1;
  logic [3:0]  sel1;

  // 4-bit instance
  logic        start4, en4;
  logic [3:0]  rs2_4, rd4;
  logic        busy4, done4, mis4, wbwe4, cyc4;
  logic [31:0] wbadr4, wbdat4;
  logic [3:0]  sel4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qerv_dbus_if #(.BITS_PER_CYCLE(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_we(we), .i_size(size),
    .i_signed(sgn), .i_adr(adr), .i_lsb(lsb_in), .i_en(en1), .i_rs2(rs2_1),
    .o_rd(rd1), .o_busy(busy1), .o_done(done1), .o_misalign(mis1),
    .o_wb_adr(wbadr1), .o_wb_dat(wbdat1), .o_wb_sel(sel1), .o_wb_we(wbwe1),
    .o_wb_cyc(cyc1), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack)
  );

  qerv_dbus_if #(.BITS_PER_CYCLE(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_we(we), .i_size(size),
    .i_signed(sgn), .i_adr(adr), .i_lsb(lsb_in), .i_en(en4), .i_rs2(rs2_4),
    .o_rd(rd4), .o_busy(busy4), .o_done(done4), .o_misalign(mis4),
    .o_wb_adr(wbadr4), .o_wb_dat(wbdat4), .o_wb_sel(sel4), .o_wb_we(wbwe4),
    .o_wb_cyc(cyc4), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Serial store on the 1-bit instance, with a spurious start mid-collection
  task automatic store1(input logic [1:0] sz, input logic [1:0] lsb, input logic [31:0] d,
                        input logic [3:0] exp_sel, input logic [31:0] exp_dat);
    @(negedge clk);
    we = 1'b1; size = sz; lsb_in = lsb; adr = 32'h0000_1003; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check_val("st1_busy", 32'(busy1), 32'd1);
    for (int k = 0; k < 32; k++) begin
      en1 = 1'b1;
      rs2_1 = d[k];
      if (k == 10) begin start1 = 1'b1; we = 1'b0; end
      else start1 = 1'b0;
      if (k == 31) check_val("st1_cyc_before_last", 32'(cyc1), 32'd0);
      @(negedge clk);
    end
    en1 = 1'b0; start1 = 1'b0; we = 1'b1;
    check_val("st1_cyc", 32'(cyc1), 32'd1);
    check_val("st1_we", 32'(wbwe1), 32'd1);
    check_val("st1_sel", 32'(sel1), 32'(exp_sel));
    check_val("st1_dat", wbdat1, exp_dat);
    check_val("st1_adr", wbadr1, 32'h0000_1000);
    // Stall with i_en asserted, which REQ must ignore
    en1 = 1'b1;
    repeat (3) @(negedge clk);
    en1 = 1'b0;
    check_val("st1_stall_cyc", 32'(cyc1), 32'd1);
    check_val("st1_stall_done", 32'(done1), 32'd0);
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    check_val("st1_ack_cyc", 32'(cyc1), 32'd0);
    check_val("st1_ack_sel", 32'(sel1), 32'd0);
    check_val("st1_ack_we", 32'(wbwe1), 32'd0);
    check_val("st1_done", 32'(done1), 32'd1);
    @(negedge clk);
    check_val("st1_done_pulse", 32'(done1), 32'd0);
    check_val("st1_idle", 32'(busy1), 32'd0);
  endtask

  // Load on the 1-bit instance; collects the serial o_rd stream
  task automatic load1(input logic [1:0] sz, input logic sg, input logic [1:0] lsb,
                       input logic [31:0] rdt, input logic [3:0] exp_sel, input logic [31:0] exp);
    logic [31:0] res;
    res = '0;
    @(negedge clk);
    we = 1'b0; size = sz; sgn = sg; lsb_in = lsb; adr = 32'h0000_2000; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; sgn = ~sg; size = ~sz; lsb_in = ~lsb;
    check_val("ld1_cyc", 32'(cyc1), 32'd1);
    check_val("ld1_we", 32'(wbwe1), 32'd0);
    check_val("ld1_sel", 32'(sel1), 32'(exp_sel));
    repeat (2) @(negedge clk);
    wb_rdt = rdt; wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0; wb_rdt = 32'h5555_AAAA;
    check_val("ld1_ack_cyc", 32'(cyc1), 32'd0);
    check_val("ld1_ret_busy", 32'(busy1), 32'd1);
    for (int k = 0; k < 32; k++) begin
      en1 = 1'b1;
      #1;
      res[k] = rd1[0];
      @(negedge clk);
    end
    en1 = 1'b0;
    check_val("ld1_data", res, exp);
    check_val("ld1_done", 32'(done1), 32'd1);
    @(negedge clk);
    check_val("ld1_done_pulse", 32'(done1), 32'd0);
  endtask

  initial begin
    logic [31:0] d4;
    rst = 1'b1; we = 1'b0; sgn = 1'b0; size = SZ_BYTE; lsb_in = 2'b00;
    adr = '0; wb_rdt = '0; wb_ack = 1'b0;
    start1 = 1'b0; en1 = 1'b0; rs2_1 = '0;
    start4 = 1'b0; en4 = 1'b0; rs2_4 = '0;
    repeat (3) @(negedge clk);
    check_val("rst_cyc", 32'(cyc1), 32'd0);
    check_val("rst_busy", 32'(busy1), 32'd0);
    check_val("rst_done", 32'(done1), 32'd0);
    check_val("rst_mis", 32'(mis1), 32'd0);
    check_val("rst_sel", 32'(sel1), 32'd0);
    check_val("rst_adr", wbadr1, 32'd0);
    check_val("rst_dat", wbdat1, 32'd0);
    check_val("rst_rd", 32'(rd1), 32'd0);
    check_val("rst_cyc4", 32'(cyc4), 32'd0);
    rst = 1'b0;

    // Ack while idle must not start anything
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    check_val("idle_ack_cyc", 32'(cyc1), 32'd0);
    check_val("idle_ack_done", 32'(done1), 32'd0);

    // Byte store at offset 2
    store1(SZ_BYTE, 2'd2, 32'h0000_00A5, 4'b0100, 32'hA5A5_A5A5);
    // Half store at offset 2
    store1(SZ_HALF, 2'd2, 32'hCAFE_BEEF, 4'b1100, 32'hBEEF_BEEF);
    // Size 11 behaves as word
    store1(2'b11, 2'd0, 32'h1357_9BDF, 4'b1111, 32'h1357_9BDF);

    // Loads
    load1(SZ_HALF, 1'b1, 2'd2, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
    load1(SZ_BYTE, 1'b0, 2'd3, 32'hF000_0000, 4'b1000, 32'h0000_00F0);
    load1(SZ_BYTE, 1'b1, 2'd3, 32'hF000_0000, 4'b1000, 32'hFFFF_FFF0);
    load1(SZ_HALF, 1'b1, 2'd0, 32'h0000_7FFF, 4'b0011, 32'h0000_7FFF);

    // Misaligned word load
    @(negedge clk);
    we = 1'b0; size = SZ_WORD; lsb_in = 2'd1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check_val("mis_pulse", 32'(mis1), 32'd1);
    check_val("mis_cyc", 32'(cyc1), 32'd0);
    check_val("mis_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    check_val("mis_pulse_end", 32'(mis1), 32'd0);
    check_val("mis_cyc_after", 32'(cyc1), 32'd0);

    // Misaligned half at odd offset
    size = SZ_HALF; lsb_in = 2'd3; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check_val("mis_half", 32'(mis1), 32'd1);

    // 4-bit store word with i_en toggling
    d4 = 32'h1234_5678;
    @(negedge clk);
    we = 1'b1; size = SZ_WORD; lsb_in = 2'd0; adr = 32'h0000_3000; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int b = 0; b < 8; b++) begin
      en4 = 1'b0; rs2_4 = 4'hF;
      @(negedge clk);
      if (b == 7) check_val("w4_cyc_before_8th", 32'(cyc4), 32'd0);
      en4 = 1'b1; rs2_4 = d4[4*b +: 4];
      @(negedge clk);
    end
    en4 = 1'b0;
    check_val("w4_cyc", 32'(cyc4), 32'd1);
    check_val("w4_dat", wbdat4, 32'h1234_5678);
    check_val("w4_sel", 32'(sel4), 32'hF);
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    check_val("w4_done", 32'(done4), 32'd1);
    check_val("w4_cyc_drop", 32'(cyc4), 32'd0);

    // Reset while a load waits for ack, with a concurrent ack
    @(negedge clk);
    we = 1'b0; size = SZ_WORD; lsb_in = 2'd0; adr = 32'h0000_4000; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (5) @(negedge clk);
    check_val("rr_wait_cyc", 32'(cyc1), 32'd1);
    rst = 1'b1; wb_ack = 1'b1;
    @(negedge clk);
    check_val("rr_cyc", 32'(cyc1), 32'd0);
    check_val("rr_done", 32'(done1), 32'd0);
    check_val("rr_busy", 32'(busy1), 32'd0);
    rst = 1'b0; wb_ack = 1'b0;
    @(negedge clk);
    check_val("rr_done_after", 32'(done1), 32'd0);
    load1(SZ_WORD, 1'b0, 2'd0, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
